// File: rtl/audio_i2s.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : audio_i2s
// Purpose  : Converts unsigned 10-bit L/R mixer sums to signed 16-bit PCM and
//            serialises them as a Philips I2S stream. Optional macro
//            AUDIO_SDM_EN adds per-channel first-order sigma-delta outputs.
// Revision : 1.0
// ============================================================================
module audio_i2s #(
    parameter int DIV = 7
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [9:0] laudio,
    input  logic [9:0] raudio,
    output logic       sck,
    output logic       lrck,
    output logic       sdo,
`ifdef AUDIO_SDM_EN
    output logic       dsl,
    output logic       dsr,
`endif
    output logic       strobe
);

    localparam logic [7:0] c_DIV_LAST = 8'(DIV - 1);

    logic [7:0]  div_q,   div_d;
    logic        sck_q,   sck_d;
    logic [4:0]  slot_q,  slot_d;
    logic        lrck_q,  lrck_d;
    logic        sdo_q,   sdo_d;
    logic        strobe_q, strobe_d;
    logic [15:0] lword_q, lword_d;
    logic [15:0] rword_q, rword_d;

    logic        w_tick;
    logic        w_fall;
    logic [4:0]  w_slot_nx;
    logic [3:0]  w_lidx;
    logic [3:0]  w_ridx;
    logic [15:0] w_lconv;
    logic [15:0] w_rconv;

    assign w_tick    = (div_q == c_DIV_LAST);
    assign w_fall    = w_tick & sck_q;
    assign w_slot_nx = slot_q + 5'd1;
    // Slots 1..16 carry L[15..0]; slots 17..31 carry R[15..1].
    assign w_lidx    = 4'(5'd16 - w_slot_nx);
    assign w_ridx    = 4'(5'd0 - w_slot_nx);
    assign w_lconv   = {~laudio[9], laudio[8:0], 6'b000000};
    assign w_rconv   = {~raudio[9], raudio[8:0], 6'b000000};

    always_comb begin
        div_d    = div_q + 8'd1;
        sck_d    = sck_q;
        slot_d   = slot_q;
        lrck_d   = lrck_q;
        sdo_d    = sdo_q;
        strobe_d = 1'b0;
        lword_d  = lword_q;
        rword_d  = rword_q;
        if (w_tick) begin
            div_d = 8'd0;
            sck_d = ~sck_q;
        end
        if (w_fall) begin
            slot_d = w_slot_nx;
            if (w_slot_nx == 5'd0)  lrck_d = 1'b0;
            if (w_slot_nx == 5'd16) lrck_d = 1'b1;
            if (w_slot_nx == 5'd1) begin
                lword_d  = w_lconv;
                rword_d  = w_rconv;
                strobe_d = 1'b1;
            end
            // lword_d so slot 1 already shifts the word captured on this edge
            if (w_slot_nx == 5'd0)
                sdo_d = rword_q[0];
            else if (w_slot_nx <= 5'd16)
                sdo_d = lword_d[w_lidx];
            else
                sdo_d = rword_q[w_ridx];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_q    <= 8'd0;
            sck_q    <= 1'b0;
            slot_q   <= 5'd31;
            lrck_q   <= 1'b1;
            sdo_q    <= 1'b0;
            strobe_q <= 1'b0;
            lword_q  <= 16'h0000;
            rword_q  <= 16'h0000;
        end else begin
            div_q    <= div_d;
            sck_q    <= sck_d;
            slot_q   <= slot_d;
            lrck_q   <= lrck_d;
            sdo_q    <= sdo_d;
            strobe_q <= strobe_d;
            lword_q  <= lword_d;
            rword_q  <= rword_d;
        end
    end

    assign sck    = sck_q;
    assign lrck   = lrck_q;
    assign sdo    = sdo_q;
    assign strobe = strobe_q;

`ifdef AUDIO_SDM_EN
    logic [10:0] lacc_q, lacc_d;
    logic [10:0] racc_q, racc_d;

    // Bit 10 holds the carry of the last add; it is the modulator output.
    always_comb begin
        lacc_d = {1'b0, lacc_q[9:0]} + {1'b0, laudio};
        racc_d = {1'b0, racc_q[9:0]} + {1'b0, raudio};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lacc_q <= 11'd0;
            racc_q <= 11'd0;
        end else begin
            lacc_q <= lacc_d;
            racc_q <= racc_d;
        end
    end

    assign dsl = lacc_q[10];
    assign dsr = racc_q[10];
`endif

endmodule
`default_nettype wire
